// File: rtl/jtag_tdr_chain.sv
// JTAG instruction register plus BYPASS / IDCODE / USER data registers.
// The TAP state is an input. Every register acts on the state present in the
// cycle before its clock edge. TDO is the combinational LSB of whichever
// register is shifting.
module jtag_tdr_chain #(
    parameter int          IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VAL   = 32'h1000_0001,
    parameter int          USER_WIDTH   = 8,
    parameter int          INSTR_IDCODE = 1,
    parameter int          INSTR_USER   = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [3:0]            state,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  tdo_en,
    output logic [IR_WIDTH-1:0]   ir,
    input  logic [USER_WIDTH-1:0] user_dr_in,
    output logic [USER_WIDTH-1:0] user_dr_out,
    output logic                  user_update
);

    // TAP state codes this block reacts to; all other states hold everything
    localparam logic [3:0] ST_TLR   = 4'd15;
    localparam logic [3:0] ST_CAPDR = 4'd6;
    localparam logic [3:0] ST_SHDR  = 4'd2;
    localparam logic [3:0] ST_UPDR  = 4'd5;
    localparam logic [3:0] ST_CAPIR = 4'd14;
    localparam logic [3:0] ST_SHIR  = 4'd10;
    localparam logic [3:0] ST_UPIR  = 4'd13;

    localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(INSTR_IDCODE);
    localparam logic [IR_WIDTH-1:0] OP_USER   = IR_WIDTH'(INSTR_USER);

    logic [IR_WIDTH-1:0]   r_ir;
    logic [IR_WIDTH-1:0]   r_ir_sh;
    logic [31:0]           r_id_sh;
    logic [USER_WIDTH-1:0] r_usr_sh;
    logic                  r_bypass;
    logic [USER_WIDTH-1:0] r_user_dr_out;
    logic                  r_user_update;

    logic                  w_sel_idcode;
    logic                  w_sel_user;
    logic [USER_WIDTH-1:0] w_usr_next;

    // IDCODE wins if both opcodes are ever configured the same.
    // Anything unrecognised falls through to BYPASS.
    assign w_sel_idcode = (r_ir == OP_IDCODE);
    assign w_sel_user   = !w_sel_idcode && (r_ir == OP_USER);

    // A 1-bit USER register has nothing above bit 0, so it simply loads TDI
    generate
        if (USER_WIDTH == 1) begin : g_usr1
            assign w_usr_next = tdi;
        end else begin : g_usrn
            assign w_usr_next = {tdi, r_usr_sh[USER_WIDTH-1:1]};
        end
    endgenerate

    // Instruction path: capture the fixed 01 pattern, shift LSB first, and
    // commit only at UPIR. Test-logic-reset restores IDCODE without touching
    // the shift register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ir    <= OP_IDCODE;
            r_ir_sh <= '0;
        end else begin
            case (state)
                ST_CAPIR: r_ir_sh <= IR_WIDTH'(2'b01);
                ST_SHIR:  r_ir_sh <= {tdi, r_ir_sh[IR_WIDTH-1:1]};
                ST_UPIR:  r_ir    <= r_ir_sh;
                ST_TLR:   r_ir    <= OP_IDCODE;
                default:  ;
            endcase
        end
    end

    // Data registers: only the register the current instruction selects
    // captures or shifts. The unselected ones keep their contents.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_id_sh  <= '0;
            r_usr_sh <= '0;
            r_bypass <= 1'b0;
        end else if (state == ST_CAPDR) begin
            if (w_sel_idcode)    r_id_sh  <= IDCODE_VAL;
            else if (w_sel_user) r_usr_sh <= user_dr_in;
            else                 r_bypass <= 1'b0;
        end else if (state == ST_SHDR) begin
            if (w_sel_idcode)    r_id_sh  <= {tdi, r_id_sh[31:1]};
            else if (w_sel_user) r_usr_sh <= w_usr_next;
            else                 r_bypass <= tdi;
        end
    end

    // USER parallel output and its strobe. The strobe is high for the single
    // cycle after a USER update.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_user_dr_out <= '0;
            r_user_update <= 1'b0;
        end else begin
            r_user_update <= (state == ST_UPDR) && w_sel_user;
            if ((state == ST_UPDR) && w_sel_user) begin
                r_user_dr_out <= r_usr_sh;
            end
        end
    end

    // Serial output: the LSB of the active shift path, forced low elsewhere
    always_comb begin
        tdo = 1'b0;
        case (state)
            ST_SHIR: tdo = r_ir_sh[0];
            ST_SHDR: begin
                if (w_sel_idcode)    tdo = r_id_sh[0];
                else if (w_sel_user) tdo = r_usr_sh[0];
                else                 tdo = r_bypass;
            end
            default: tdo = 1'b0;
        endcase
    end

    assign tdo_en      = (state == ST_SHIR) || (state == ST_SHDR);
    assign ir          = r_ir;
    assign user_dr_out = r_user_dr_out;
    assign user_update = r_user_update;

endmodule

// File: tb/tb_jtag_tdr_chain.sv
// Bench for jtag_tdr_chain. It has three parts:
//  - a fixed vector table covering an IR scan and a BYPASS scan;
//  - hand-written IDCODE, USER, reset-abort and TLR sequences;
//  - a random walk over legal TAP transitions.
// Every cycle is also checked against a queue-based model of the registers.
module tb_jtag_tdr_chain;

    localparam logic [3:0] S_TLR   = 4'd15, S_RTI   = 4'd12, S_SELDR = 4'd7,  S_CAPDR = 4'd6;
    localparam logic [3:0] S_SHDR  = 4'd2,  S_EX1DR = 4'd1,  S_PSDR  = 4'd3,  S_EX2DR = 4'd0;
    localparam logic [3:0] S_UPDR  = 4'd5,  S_SELIR = 4'd4,  S_CAPIR = 4'd14, S_SHIR  = 4'd10;
    localparam logic [3:0] S_EX1IR = 4'd9,  S_PSIR  = 4'd11, S_EX2IR = 4'd8,  S_UPIR  = 4'd13;
    localparam logic [31:0] IDC = 32'h1000_0001;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] state = S_TLR;
    logic       tdi = 1'b0;
    logic       tdo;
    logic       tdo_en;
    logic [3:0] ir;
    logic [7:0] user_dr_in = 8'h00;
    logic [7:0] user_dr_out;
    logic       user_update;

    int n_tests = 0;
    int n_fail  = 0;

    jtag_tdr_chain dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .state       (state),
        .tdi         (tdi),
        .tdo         (tdo),
        .tdo_en      (tdo_en),
        .ir          (ir),
        .user_dr_in  (user_dr_in),
        .user_dr_out (user_dr_out),
        .user_update (user_update)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model: registers as bit queues, front = LSB = tdo
    int         m_ir;
    bit         m_irq[$];
    bit         m_idq[$];
    bit         m_usq[$];
    bit         m_byq[$];
    logic [7:0] m_user_out;
    bit         m_upd;

    function automatic int m_sel();
        if (m_ir == 1) return 1;
        if (m_ir == 2) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_ir = 1;
        m_irq.delete(); repeat (4)  m_irq.push_back(1'b0);
        m_idq.delete(); repeat (32) m_idq.push_back(1'b0);
        m_usq.delete(); repeat (8)  m_usq.push_back(1'b0);
        m_byq.delete(); m_byq.push_back(1'b0);
        m_user_out = 8'h00;
        m_upd = 1'b0;
    endtask

    function automatic bit model_tdo(input logic [3:0] st);
        if (st == S_SHIR) return m_irq[0];
        if (st == S_SHDR) begin
            case (m_sel())
                1: return m_idq[0];
                2: return m_usq[0];
                default: return m_byq[0];
            endcase
        end
        return 1'b0;
    endfunction

    task automatic model_step(input logic [3:0] st, input logic t, input logic [7:0] u);
        int sel;
        bit upd_n;
        logic [3:0] iv;
        logic [7:0] v;
        sel = m_sel();
        upd_n = (st == S_UPDR) && (sel == 2);
        case (st)
            S_CAPIR: begin
                m_irq.delete(); m_irq.push_back(1'b1); repeat (3) m_irq.push_back(1'b0);
            end
            S_SHIR: begin
                void'(m_irq.pop_front()); m_irq.push_back(t);
            end
            S_UPIR: begin
                for (int i = 0; i < 4; i++) iv[i] = m_irq[i];
                m_ir = int'(iv);
            end
            S_TLR: m_ir = 1;
            S_CAPDR: begin
                if (sel == 1) begin
                    m_idq.delete(); for (int i = 0; i < 32; i++) m_idq.push_back(IDC[i]);
                end else if (sel == 2) begin
                    m_usq.delete(); for (int i = 0; i < 8; i++) m_usq.push_back(u[i]);
                end else begin
                    m_byq.delete(); m_byq.push_back(1'b0);
                end
            end
            S_SHDR: begin
                if (sel == 1)      begin void'(m_idq.pop_front()); m_idq.push_back(t); end
                else if (sel == 2) begin void'(m_usq.pop_front()); m_usq.push_back(t); end
                else               begin void'(m_byq.pop_front()); m_byq.push_back(t); end
            end
            S_UPDR: begin
                if (sel == 2) begin
                    for (int i = 0; i < 8; i++) v[i] = m_usq[i];
                    m_user_out = v;
                end
            end
            default: ;
        endcase
        m_upd = upd_n;
    endtask

    function automatic logic [3:0] tap_next(input logic [3:0] s, input bit tms);
        case (s)
            S_TLR:   return tms ? S_TLR   : S_RTI;
            S_RTI:   return tms ? S_SELDR : S_RTI;
            S_SELDR: return tms ? S_SELIR : S_CAPDR;
            S_CAPDR: return tms ? S_EX1DR : S_SHDR;
            S_SHDR:  return tms ? S_EX1DR : S_SHDR;
            S_EX1DR: return tms ? S_UPDR  : S_PSDR;
            S_PSDR:  return tms ? S_EX2DR : S_PSDR;
            S_EX2DR: return tms ? S_UPDR  : S_SHDR;
            S_UPDR:  return tms ? S_SELDR : S_RTI;
            S_SELIR: return tms ? S_TLR   : S_CAPIR;
            S_CAPIR: return tms ? S_EX1IR : S_SHIR;
            S_SHIR:  return tms ? S_EX1IR : S_SHIR;
            S_EX1IR: return tms ? S_UPIR  : S_PSIR;
            S_PSIR:  return tms ? S_EX2IR : S_PSIR;
            S_EX2IR: return tms ? S_UPIR  : S_SHIR;
            default: return tms ? S_SELDR : S_RTI;
        endcase
    endfunction

    // ---------------- checking helpers
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic [3:0] st);
        chk("tdo", 32'(tdo), 32'(model_tdo(st)));
        chk("tdo_en", 32'(tdo_en), 32'((st == S_SHIR) || (st == S_SHDR)));
        chk("ir", 32'(ir), 32'(m_ir));
        chk("user_dr_out", 32'(user_dr_out), 32'(m_user_out));
        chk("user_update", 32'(user_update), 32'(m_upd));
    endtask

    // Drive one TAP cycle at the falling edge, check, then advance the model
    task automatic step(input logic [3:0] st, input logic t, input logic [7:0] u);
        @(negedge CLK);
        state = st;
        tdi = t;
        user_dr_in = u;
        #1;
        check_outputs(st);
        model_step(st, t, u);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        state = S_TLR;
        #1;
        model_reset();
        check_outputs(S_TLR);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    // From RTI: load a 4-bit instruction and return to RTI
    task automatic ir_scan(input logic [3:0] v);
        step(S_SELDR, 1'b0, 8'h00);
        step(S_SELIR, 1'b0, 8'h00);
        step(S_CAPIR, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(S_SHIR, v[i], 8'h00);
        step(S_EX1IR, 1'b0, 8'h00);
        step(S_UPIR, 1'b0, 8'h00);
        step(S_RTI, 1'b0, 8'h00);
    endtask

    // ---------------- vector table
    typedef struct {
        logic [3:0] st;
        logic       t;
        logic       exp_tdo;
        logic [3:0] exp_ir;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic [3:0] st, input logic t, input logic e_tdo, input logic [3:0] e_ir);
        vec_t v;
        v.st = st; v.t = t; v.exp_tdo = e_tdo; v.exp_ir = e_ir;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] got32;
        logic [7:0]  got8;
        logic [7:0]  pat;
        logic [3:0]  cur;
        bit          tms;

        model_reset();
        // Scenario: IR scan of 4'hF selects BYPASS, then a BYPASS scan of 1,0,1,1
        add(S_TLR,   1'b0, 1'b0, 4'h1);
        add(S_RTI,   1'b0, 1'b0, 4'h1);
        add(S_SELDR, 1'b0, 1'b0, 4'h1);
        add(S_SELIR, 1'b0, 1'b0, 4'h1);
        add(S_CAPIR, 1'b0, 1'b0, 4'h1);
        add(S_SHIR,  1'b1, 1'b1, 4'h1);
        add(S_SHIR,  1'b1, 1'b0, 4'h1);
        add(S_SHIR,  1'b1, 1'b0, 4'h1);
        add(S_SHIR,  1'b1, 1'b0, 4'h1);
        add(S_EX1IR, 1'b0, 1'b0, 4'h1);
        add(S_UPIR,  1'b0, 1'b0, 4'h1);
        add(S_RTI,   1'b0, 1'b0, 4'hF);
        add(S_SELDR, 1'b0, 1'b0, 4'hF);
        add(S_CAPDR, 1'b0, 1'b0, 4'hF);
        add(S_SHDR,  1'b1, 1'b0, 4'hF);
        add(S_SHDR,  1'b0, 1'b1, 4'hF);
        add(S_SHDR,  1'b1, 1'b0, 4'hF);
        add(S_SHDR,  1'b1, 1'b1, 4'hF);
        add(S_EX1DR, 1'b0, 1'b0, 4'hF);
        add(S_UPDR,  1'b0, 1'b0, 4'hF);
        add(S_RTI,   1'b0, 1'b0, 4'hF);

        repeat (2) @(negedge CLK);
        do_reset();

        foreach (vecs[k]) begin
            step(vecs[k].st, vecs[k].t, 8'h00);
            chk("vec_tdo", 32'(tdo), 32'(vecs[k].exp_tdo));
            chk("vec_ir", 32'(ir), 32'(vecs[k].exp_ir));
        end

        // IDCODE scan straight out of reset
        do_reset();
        step(S_TLR, 1'b0, 8'h00);
        step(S_RTI, 1'b0, 8'h00);
        step(S_SELDR, 1'b0, 8'h00);
        step(S_CAPDR, 1'b0, 8'h00);
        for (int i = 0; i < 32; i++) begin
            step(S_SHDR, 1'b0, 8'h00);
            got32[i] = tdo;
            chk("idcode_ir", 32'(ir), 32'h1);
        end
        chk("idcode_scan", got32, 32'h1000_0001);

        // USER scan: capture 3C, shift in A5, update, one-cycle strobe
        step(S_EX1DR, 1'b0, 8'h00);
        step(S_UPDR, 1'b0, 8'h00);
        step(S_RTI, 1'b0, 8'h00);
        ir_scan(4'h2);
        chk("user_ir", 32'(ir), 32'h2);
        pat = 8'hA5;
        step(S_SELDR, 1'b0, 8'h3C);
        step(S_CAPDR, 1'b0, 8'h3C);
        for (int i = 0; i < 8; i++) begin
            step(S_SHDR, pat[i], 8'h00);
            got8[i] = tdo;
        end
        chk("user_capture", 32'(got8), 32'h3C);
        step(S_EX1DR, 1'b0, 8'h00);
        step(S_UPDR, 1'b0, 8'h00);
        chk("user_update_pre", 32'(user_update), 32'h0);
        step(S_RTI, 1'b0, 8'h00);
        chk("user_update_pulse", 32'(user_update), 32'h1);
        chk("user_dr_out", 32'(user_dr_out), 32'hA5);
        step(S_RTI, 1'b0, 8'h00);
        chk("user_update_drop", 32'(user_update), 32'h0);

        // Test-logic-reset from a loaded USER instruction
        step(S_SELDR, 1'b0, 8'h00);
        step(S_SELIR, 1'b0, 8'h00);
        step(S_TLR, 1'b0, 8'h00);
        chk("tlr_ir_before", 32'(ir), 32'h2);
        step(S_RTI, 1'b0, 8'h00);
        chk("tlr_ir_after", 32'(ir), 32'h1);
        chk("tlr_user_keep", 32'(user_dr_out), 32'hA5);

        // Reset asserted on the 5th bit of a USER shift
        ir_scan(4'h2);
        step(S_SELDR, 1'b0, 8'h3C);
        step(S_CAPDR, 1'b0, 8'h3C);
        for (int i = 0; i < 4; i++) step(S_SHDR, pat[i], 8'h00);
        @(negedge CLK);
        state = S_SHDR;
        tdi = pat[4];
        #1;
        RESET = 1'b1;
        #1;
        model_reset();
        chk("abort_ir", 32'(ir), 32'h1);
        chk("abort_user_out", 32'(user_dr_out), 32'h0);
        chk("abort_tdo", 32'(tdo), 32'h0);
        check_outputs(S_SHDR);
        @(negedge CLK);
        RESET = 1'b0;
        step(S_TLR, 1'b0, 8'h00);
        step(S_RTI, 1'b0, 8'h00);
        step(S_SELDR, 1'b0, 8'h00);
        step(S_CAPDR, 1'b0, 8'h00);
        for (int i = 0; i < 32; i++) begin
            step(S_SHDR, 1'b0, 8'h00);
            got32[i] = tdo;
        end
        chk("abort_idcode", got32, 32'h1000_0001);

        // Random walk through legal TAP transitions
        do_reset();
        cur = S_TLR;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                cur = S_TLR;
            end else begin
                tms = ($urandom_range(0, 9) < 4);
                step(cur, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
                cur = tap_next(cur, tms);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
